// File: rtl/bnn_cmd_seq.sv
// Command sequencer for one fully-connected layer pass on the BNN memory/accumulator block.
// Issues INI, n_words ACC, POOL and ACTIV, prefetching input words one at a time.
module bnn_cmd_seq #(
   parameter int unsigned IN_AW = 8,
   parameter int unsigned LEN_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] n_words,
   input  logic [9:0]       param_base,
   input  logic [IN_AW-1:0] in_base,
   input  logic [15:0]      ini_val,
   output logic             busy,
   output logic             done,
   output logic             in_re,
   output logic [IN_AW-1:0] in_addr,
   input  logic [31:0]      in_rdata,
   output logic             b_req,
   output logic [31:0]      p_addr,
   output logic [31:0]      p_wdata,
   output logic [3:0]       p_be,
   input  logic             p_gnt,
   input  logic             p_rvalid,
   input  logic [31:0]      p_rdata,
   output logic             out_we,
   output logic [31:0]      out_data
);

   localparam logic [31:0] AddrIni   = 32'h0000_1000;
   localparam logic [31:0] AddrPool  = 32'h0000_1004;
   localparam logic [31:0] AddrActiv = 32'h0000_100C;

   typedef enum logic [2:0] {
      StIdle, StIni, StAcc, StPool, StActiv, StWaitAct, StWr
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] n_q, n_d;
   logic [9:0]       pbase_q, pbase_d;
   logic [IN_AW-1:0] ibase_q, ibase_d;
   logic [LEN_W-1:0] k_q, k_d;
   logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             rd_pend_q, rd_pend_d;
   logic [31:0]      word_q, word_d;
   logic             word_vld_q, word_vld_d;
   logic             b_req_q, b_req_d;
   logic [31:0]      p_addr_q, p_addr_d;
   logic [31:0]      p_wdata_q, p_wdata_d;
   logic [31:0]      out_data_q, out_data_d;
   logic             accept;
   logic             rd_issue;

   function automatic logic [31:0] acc_addr(input logic [9:0] base, input logic [LEN_W-1:0] k);
      logic [9:0] idx;
      idx = base + 10'(k);
      return {20'h0, idx, 2'b00};
   endfunction

   assign accept = b_req_q & p_gnt;
   // Single-entry word buffer: fetch only when it is empty and nothing is in flight.
   assign rd_issue = ((state_q == StIni) || (state_q == StAcc)) && (rd_cnt_q < n_q) &&
                     !rd_pend_q && !word_vld_q;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      pbase_d    = pbase_q;
      ibase_d    = ibase_q;
      k_d        = k_q;
      rd_cnt_d   = rd_cnt_q;
      rd_pend_d  = rd_issue;
      word_d     = word_q;
      word_vld_d = word_vld_q;
      b_req_d    = b_req_q;
      p_addr_d   = p_addr_q;
      p_wdata_d  = p_wdata_q;
      out_data_d = out_data_q;

      if (rd_issue) rd_cnt_d = rd_cnt_q + LEN_W'(1);
      if (rd_pend_q) begin
         word_d     = in_rdata;
         word_vld_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               n_d        = n_words;
               pbase_d    = param_base;
               ibase_d    = in_base;
               k_d        = '0;
               rd_cnt_d   = '0;
               word_vld_d = 1'b0;
               b_req_d    = 1'b1;
               p_addr_d   = AddrIni;
               p_wdata_d  = {16'h0, ini_val};
               state_d    = StIni;
            end
         end
         StIni: begin
            if (accept) begin
               if (n_q == '0) begin
                  p_addr_d  = AddrPool;
                  p_wdata_d = '0;
                  state_d   = StPool;
               end else begin
                  k_d     = '0;
                  state_d = StAcc;
                  if (word_vld_q) begin
                     p_addr_d   = acc_addr(pbase_q, '0);
                     p_wdata_d  = word_q;
                     word_vld_d = 1'b0;
                  end else begin
                     b_req_d = 1'b0;
                  end
               end
            end
         end
         StAcc: begin
            if (b_req_q) begin
               if (accept) begin
                  if (k_q == n_q - LEN_W'(1)) begin
                     p_addr_d  = AddrPool;
                     p_wdata_d = '0;
                     state_d   = StPool;
                  end else begin
                     k_d = k_q + LEN_W'(1);
                     // Back-to-back only when the next word is already buffered.
                     if (word_vld_q) begin
                        p_addr_d   = acc_addr(pbase_q, k_q + LEN_W'(1));
                        p_wdata_d  = word_q;
                        word_vld_d = 1'b0;
                     end else begin
                        b_req_d = 1'b0;
                     end
                  end
               end
            end else if (word_vld_q) begin
               b_req_d    = 1'b1;
               p_addr_d   = acc_addr(pbase_q, k_q);
               p_wdata_d  = word_q;
               word_vld_d = 1'b0;
            end
         end
         StPool: begin
            if (accept) begin
               p_addr_d  = AddrActiv;
               p_wdata_d = '0;
               state_d   = StActiv;
            end
         end
         StActiv: begin
            if (accept) begin
               b_req_d = 1'b0;
               state_d = StWaitAct;
            end
         end
         StWaitAct: begin
            if (p_rvalid) begin
               out_data_d = p_rdata;
               state_d    = StWr;
            end
         end
         StWr: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         n_q        <= '0;
         pbase_q    <= '0;
         ibase_q    <= '0;
         k_q        <= '0;
         rd_cnt_q   <= '0;
         rd_pend_q  <= 1'b0;
         word_q     <= '0;
         word_vld_q <= 1'b0;
         b_req_q    <= 1'b0;
         p_addr_q   <= '0;
         p_wdata_q  <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         pbase_q    <= pbase_d;
         ibase_q    <= ibase_d;
         k_q        <= k_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_pend_q  <= rd_pend_d;
         word_q     <= word_d;
         word_vld_q <= word_vld_d;
         b_req_q    <= b_req_d;
         p_addr_q   <= p_addr_d;
         p_wdata_q  <= p_wdata_d;
         out_data_q <= out_data_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StWr);
   assign out_we   = (state_q == StWr);
   assign in_re    = rd_issue;
   assign in_addr  = ibase_q + IN_AW'(rd_cnt_q);
   assign b_req    = b_req_q;
   assign p_addr   = p_addr_q;
   assign p_wdata  = p_wdata_q;
   assign p_be     = 4'hF;
   assign out_data = out_data_q;

endmodule
